// File: rtl/linebuffer.sv
// Single-line circular pixel buffer that exposes KERNEL_W consecutive pixels,
// starting at the read pointer, as a combinational window for a sliding-window kernel.
module linebuffer #(
  parameter int DATA_W     = 8,
  parameter int KERNEL_W   = 3,
  parameter int RESOLUTION = 512
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              wr_valid_i,
  output logic [DATA_W-1:0] data_o [KERNEL_W-1:0],
  input  logic              rd_valid_i
);

  localparam int PTR_W = $clog2(RESOLUTION);
  localparam int IDX_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_ADDR = PTR_W'(RESOLUTION - 1);
  localparam logic [IDX_W-1:0] DEPTH     = IDX_W'(RESOLUTION);

  logic [DATA_W-1:0] mem [RESOLUTION];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [IDX_W-1:0]  win_idx;

  // The whole array clears on reset so stale pixels never leak into the window.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      wr_ptr <= '0;
      for (int i = 0; i < RESOLUTION; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_valid_i) begin
      mem[wr_ptr] <= data_i;
      wr_ptr      <= (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      rd_ptr <= '0;
    end else if (rd_valid_i) begin
      rd_ptr <= (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;
    end
  end

  // rd_ptr + k stays below 2*RESOLUTION, so a single conditional subtract wraps it.
  always_comb begin
    win_idx = '0;
    for (int k = 0; k < KERNEL_W; k++) begin
      win_idx = {1'b0, rd_ptr} + IDX_W'(k);
      if (win_idx >= DEPTH) begin
        win_idx = win_idx - DEPTH;
      end
      data_o[k] = mem[win_idx[PTR_W-1:0]];
    end
  end

endmodule

// File: tb/tb_linebuffer.sv
// Directed and scoreboard-checked bench for linebuffer with the default
// 8-bit, 3-wide, 512-deep configuration.
module tb_linebuffer;

  logic       clk_i;
  logic       arst_n_i;
  logic [7:0] data_i;
  logic       wr_valid_i;
  logic       rd_valid_i;
  logic [7:0] data_o [2:0];

  int n_compared;
  int n_mismatched;

  logic [7:0] mm [512];
  int         mw;
  int         mr;

  linebuffer #(
    .DATA_W    (8),
    .KERNEL_W  (3),
    .RESOLUTION(512)
  ) dut (
    .clk_i     (clk_i),
    .arst_n_i  (arst_n_i),
    .data_i    (data_i),
    .wr_valid_i(wr_valid_i),
    .data_o    (data_o),
    .rd_valid_i(rd_valid_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic model_clear();
    for (int i = 0; i < 512; i++) mm[i] = 8'h00;
    mw = 0;
    mr = 0;
  endtask

  // Drives one cycle of stimulus, updates the reference model on the edge, and
  // returns 1 time unit after that edge so callers can sample the outputs.
  task automatic step(input logic wv, input logic [7:0] d, input logic rv);
    wr_valid_i = wv;
    data_i     = d;
    rd_valid_i = rv;
    @(posedge clk_i);
    if (wv) begin
      mm[mw] = d;
      mw = (mw + 1) % 512;
    end
    if (rv) mr = (mr + 1) % 512;
    #1;
    wr_valid_i = 1'b0;
    rd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    arst_n_i   = 1'b0;
    wr_valid_i = 1'b1;
    rd_valid_i = 1'b0;
    data_i     = 8'($urandom_range(1, 255));
    model_clear();
    for (int c = 0; c < 4; c++) begin
      data_i = 8'($urandom_range(1, 255));
      @(posedge clk_i);
      #1;
      for (int k = 0; k < 3; k++) begin
        n_compared++;
        if (data_o[k] !== 8'h00) begin
          n_mismatched++;
          $display("[TB] FAIL reset_hold[%0d] cycle %0d: got %0h expected 00", k, c, data_o[k]);
        end
      end
    end
    wr_valid_i = 1'b0;
    arst_n_i   = 1'b1;
  endtask

  task automatic test_fill();
    logic [7:0] exp;
    for (int i = 0; i < 512; i++) begin
      step(1'b1, 8'(i % 256), 1'b0);
      for (int k = 0; k < 3; k++) begin
        exp = (k <= i) ? 8'(k) : 8'h00;
        n_compared++;
        if (data_o[k] !== exp) begin
          n_mismatched++;
          $display("[TB] FAIL fill[%0d] write %0d: got %0h expected %0h", k, i, data_o[k], exp);
        end
      end
    end
  endtask

  task automatic test_advance();
    logic [7:0] exp [3];
    step(1'b0, 8'h00, 1'b1);
    exp = '{8'd1, 8'd2, 8'd3};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL advance_one[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
    for (int c = 0; c < 509; c++) step(1'b0, 8'h00, 1'b1);
    exp = '{8'd254, 8'd255, 8'd0};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL window_wrap[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
  endtask

  task automatic test_write_wrap();
    logic [7:0] exp [3];
    step(1'b1, 8'hAA, 1'b0);
    exp = '{8'd254, 8'd255, 8'hAA};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL write_wrap[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [3];
    step(1'b0, 8'h00, 1'b1);
    exp = '{8'd255, 8'hAA, 8'd1};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL rd_511[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
    step(1'b0, 8'h00, 1'b1);
    exp = '{8'hAA, 8'd1, 8'd2};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL rd_0[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
    step(1'b1, 8'h5C, 1'b1);
    exp = '{8'h5C, 8'd2, 8'd3};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL simultaneous[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] exp [3];
    arst_n_i = 1'b0;
    #2;
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== 8'h00) begin
        n_mismatched++;
        $display("[TB] FAIL async_clear[%0d]: got %0h expected 00", k, data_o[k]);
      end
    end
    #1;
    arst_n_i = 1'b1;
    model_clear();
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    exp = '{8'h11, 8'h22, 8'h33};
    for (int k = 0; k < 3; k++) begin
      n_compared++;
      if (data_o[k] !== exp[k]) begin
        n_mismatched++;
        $display("[TB] FAIL post_reset_ptrs[%0d]: got %0h expected %0h", k, data_o[k], exp[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] exp;
    for (int c = 0; c < 700; c++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        exp = mm[(mr + k) % 512];
        n_compared++;
        if (data_o[k] !== exp) begin
          n_mismatched++;
          $display("[TB] FAIL random[%0d] cycle %0d: got %0h expected %0h", k, c, data_o[k], exp);
        end
      end
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    data_i       = 8'h00;
    wr_valid_i   = 1'b0;
    rd_valid_i   = 1'b0;
    test_reset();
    test_fill();
    test_advance();
    test_write_wrap();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
